// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    // Operand width used when the parent does not override WIDTH.
    localparam int DEFAULT_WIDTH = 8;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: one spare bit so the counter can reach WIDTH without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// master = operand producer / result consumer, slave = the controller.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/full_adder_nor.sv
// Combinational 1-bit full adder built only from NOR (pierce) gates.
// n1..n4 form XNOR(a,b); n4..n8 form XNOR(n4,cin) = a^b^cin.
// cout = NOR(n1,n5) = (a|b) & (XNOR(a,b)|cin), which is the majority function.
module full_adder_nor (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic n1, n2, n3, n4, n5, n6, n7;

    nor g1 (n1, a, b);
    nor g2 (n2, a, n1);
    nor g3 (n3, b, n1);
    nor g4 (n4, n2, n3);
    nor g5 (n5, n4, cin);
    nor g6 (n6, n4, n5);
    nor g7 (n7, cin, n5);
    nor g8 (s, n6, n7);
    nor g9 (cout, n1, n5);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts an operand set, adds it LSB first
// one bit per clock through a single full adder, then holds the result
// until the consumer takes it.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_shift;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             fa_s;
    logic             fa_cout;
    logic             in_ready;
    logic             out_valid;

    full_adder_nor u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        sum_shift            = sum_reg >> 1;
        sum_shift[WIDTH-1]   = fa_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, serial shifting, carry/flag latching and bit counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh_reg  <= bus.a;
                        b_sh_reg  <= bus.b;
                        carry_reg <= bus.cin;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    a_sh_reg  <= a_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    sum_reg   <= sum_shift;
                    carry_reg <= fa_cout;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    // On the MSB, carry_reg is the carry into the MSB and fa_cout the carry out.
                    if (cnt_reg == LAST_BIT) begin
                        cout_reg <= fa_cout;
                        ovf_reg  <= carry_reg ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases with
// literal expectations plus randomized traffic checked every cycle against
// an arithmetic reference model.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_ready = 1'b1;
    bit         m_valid = 1'b0;
    bit         m_busy  = 1'b0;
    int         m_left  = 0;
    logic [7:0] m_sum   = '0;
    bit         m_cout  = 1'b0;
    bit         m_ovf   = 1'b0;
    logic [7:0] p_sum;
    bit         p_cout;
    bit         p_ovf;
    int         full_u;
    int         full_s;
    int         acc_last = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else if (m_valid) begin
            if (bus.out_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
                m_sum   = p_sum;
                m_cout  = p_cout;
                m_ovf   = p_ovf;
            end
        end else if (bus.in_valid) begin
            full_u   = int'(bus.a) + int'(bus.b) + int'(bus.cin);
            full_s   = int'($signed(bus.a)) + int'($signed(bus.b)) + int'(bus.cin);
            p_sum    = full_u[7:0];
            p_cout   = full_u[8];
            p_ovf    = (full_s > 127) || (full_s < -128);
            m_left   = W;
            m_busy   = 1'b1;
            m_ready  = 1'b0;
            acc_last = cyc;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", bus.in_ready, m_ready);
            chk("out_valid", bus.out_valid, m_valid);
            if (m_valid) begin
                chk("sum", bus.sum, m_sum);
                chk("cout", bus.cout, m_cout);
                chk("ovf", bus.ovf, m_ovf);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_v;
        bus.cin      = tc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.cin      = 1'($urandom);
    endtask

    task automatic get_result(output logic [7:0] s, output logic co, output logic ov, output int lat);
        s = '0; co = 1'b0; ov = 1'b0; lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin
                s   = bus.sum;
                co  = bus.cout;
                ov  = bus.ovf;
                lat = cyc - acc_last;
                return;
            end
            @(negedge clk);
        end
        chk("result_timeout", bus.out_valid, 1);
    endtask

    task automatic directed(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                            input logic tc, input logic [7:0] es, input logic eco, input logic eov);
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         lat;
        bus.out_ready = 1'b1;
        send(ta, tb_v, tc);
        get_result(s, co, ov, lat);
        $display("[TB] %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d latency=%0d",
                 name, ta, tb_v, tc, s, co, ov, lat);
        chk({name, "_sum"}, s, es);
        chk({name, "_cout"}, co, eco);
        chk({name, "_ovf"}, ov, eov);
        chk({name, "_latency"}, lat, W);
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         lat;
        int         seen;
        int         acc_t[$];

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_sum", bus.sum, 0);
        chk("reset_cout", bus.cout, 0);
        chk("reset_ovf", bus.ovf, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        directed("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("add_7f_00_c1", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

        // Operands change while the sum is being computed.
        bus.out_ready = 1'b1;
        send(8'h80, 8'h80, 1'b0);
        bus.a   = 8'h00;
        bus.b   = 8'h00;
        bus.cin = 1'b0;
        get_result(s, co, ov, lat);
        $display("[TB] resample: 80+80 then inputs 00 -> sum=%02h cout=%0d ovf=%0d", s, co, ov);
        chk("resample_sum", s, 8'h00);
        chk("resample_cout", co, 1);
        chk("resample_ovf", ov, 1);
        @(negedge clk);

        // Reset on the 4th RUN cycle discards the transaction.
        send(8'h55, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_in_ready", bus.in_ready, 1);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        $display("[TB] midrun reset: out_valid seen %0d times", seen);
        chk("midrun_rst_no_valid", seen, 0);
        directed("after_rst_03_04", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        // Backpressure: result held for 5 cycles with out_ready low.
        bus.out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b1);
        get_result(s, co, ov, lat);
        chk("bp_first_sum", s, 8'h47);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_sum", bus.sum, 8'h47);
            chk("bp_cout", bus.cout, 0);
            chk("bp_ovf", bus.ovf, 0);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);
        $display("[TB] backpressure: 12+34+1 held 5 cycles, sum=%02h", s);

        // rst and in_valid on the same edge: rst wins.
        bus.in_valid = 1'b1;
        bus.a        = 8'h09;
        bus.b        = 8'h09;
        rst          = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_vs_valid_in_ready", bus.in_ready, 1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        $display("[TB] rst with in_valid: out_valid seen %0d times", seen);
        chk("rst_vs_valid_no_result", seen, 0);

        // Back-to-back acceptance spacing measured from the DUT handshake.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 8'h01;
        bus.b         = 8'h02;
        bus.cin       = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.in_ready && bus.in_valid) acc_t.push_back(cyc);
            if (acc_t.size() == 3) break;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (acc_t.size() == 3) begin
            $display("[TB] back-to-back: accept spacing %0d, %0d", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
            chk("b2b_spacing_1", acc_t[1] - acc_t[0], W + 2);
            chk("b2b_spacing_2", acc_t[2] - acc_t[1], W + 2);
        end else begin
            chk("b2b_accept_count", acc_t.size(), 3);
        end
        repeat (12) @(negedge clk);

        // Randomized traffic; the per-cycle compare checks everything.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst           = ($urandom_range(0, 149) == 0);
            bus.in_valid  = 1'($urandom);
            bus.a         = 8'($urandom);
            bus.b         = 8'($urandom);
            bus.cin       = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (bus.out_valid && bus.out_ready)
                $display("[TB] rand: sum=%02h cout=%0d ovf=%0d", bus.sum, bus.cout, bus.ovf);
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (14) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, is the operand width in bits; legal range 1..32.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  controller can accept an operand set.
REQ-006 a  input  WIDTH  addend A, unsigned or two's complement.
REQ-007 b  input  WIDTH  addend B.
REQ-008 cin  input  1  carry-in for bit 0.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.
REQ-013 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 The controller SHALL compute the sum bit-serially, LSB first, one bit per clock, through exactly one instance of the 1-bit full-adder sub-module.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture a, b and cin into shift and carry registers, clear the bit counter and enter RUN.
REQ-017 RUN: in_ready=0, out_valid=0; each cycle, feed operand bit [0] plus the carry register to the adder, shift the sum bit into the result MSB, right-shift the operands, store the new carry and increment the counter.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1, latch cout and ovf and enter DONE.
REQ-019 out_valid SHALL rise exactly WIDTH clock edges after the accepting edge.
REQ-020 DONE: out_valid=1 and in_ready=0; sum, cout and ovf SHALL stay stable until out_valid&&out_ready, then the FSM enters IDLE.
REQ-021 out_ready low in DONE SHALL stall indefinitely with no change to outputs.
REQ-022 in_valid, a, b and cin SHALL be ignored outside IDLE; the accepted operands are never re-sampled.
REQ-023 There is no IDLE bypass: the minimum spacing between accepted transactions is WIDTH+2 cycles.
REQ-024 The bit counter width SHALL be $clog2(WIDTH)+1 and SHALL never wrap; the RUN exit compare is counter == WIDTH-1.
REQ-025 WIDTH=1 SHALL spend one RUN cycle, and ovf SHALL equal cin XOR cout for that bit.
REQ-026 out_ready is a don't-care outside DONE.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE, in_ready=1 on the following cycle, out_valid=0, sum=0, cout=0, ovf=0, counter=0 and carry register=0.
REQ-028 rst asserted mid-RUN or in DONE SHALL discard the transaction with no partial result ever flagged valid.
REQ-029 When rst and in_valid are high on the same edge, rst wins and the operand set is not accepted.

Structure
REQ-030 Package serial_add_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-031 The sub-module full_adder_nor SHALL implement a 1-bit full adder (a, b, cin -> s, cout) purely from pierce (NOR) gate instances and SHALL be combinational.
REQ-032 All sequencing, the shift registers and the counter SHALL live in serial_add_ctrl.

Verification (WIDTH=8)
REQ-033 a=0x0F, b=0x01, cin=0 -> after 8 cycles sum=0x10, cout=0, ovf=0.
REQ-034 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-035 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs and out_valid stable throughout, in_ready=0; the first out_ready=1 edge returns the FSM to IDLE.
REQ-036 Operands changed while in RUN: a=0x80+b=0x80 accepted, then inputs driven to 0x00 -> sum=0x00, cout=1, ovf=1.
REQ-037 rst pulsed on the 4th RUN cycle -> out_valid is never asserted; the next transaction 0x03+0x04 gives sum=0x07.
REQ-038 Back-to-back: in_valid held high with out_ready=1 -> accepting edges are exactly 10 cycles apart.
